// File: rtl/ap_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ap_mon_pkg
// Description : Shared types and helpers for the ap_ctrl_chain performance
//               monitor. Provides the per-channel state enum, the read-port
//               field selects and a saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ap_mon_pkg;

  // Per-channel invocation state; encoding is visible in the status word.
  typedef enum logic [1:0] {
    AP_IDLE = 2'd0,
    AP_RUN  = 2'd1,
    AP_HOLD = 2'd2
  } ap_mon_state_e;

  // Read-port field selects.
  localparam logic [2:0] SEL_STARTS   = 3'd0;
  localparam logic [2:0] SEL_DONES    = 3'd1;
  localparam logic [2:0] SEL_BUSY     = 3'd2;
  localparam logic [2:0] SEL_STALL    = 3'd3;
  localparam logic [2:0] SEL_LAST_LAT = 3'd4;
  localparam logic [2:0] SEL_MAX_LAT  = 3'd5;
  localparam logic [2:0] SEL_READY    = 3'd6;
  localparam logic [2:0] SEL_STATUS   = 3'd7;

  // Widest counter the helper supports; callers zero-extend into it.
  localparam int SAT_W = 64;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ap_ch_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ap_ch_tracker
// Description : One ap_ctrl_chain channel: invocation FSM plus saturating
//               statistics counters with sticky overflow.
// Ports       : i_clock/i_reset (sync, active-low), i_stat_en (statistics
//               may change), i_clear (zero statistics), ap_* handshake
//               inputs, o_state and all statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_ch_tracker
  import ap_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_stat_en,
  input  logic             i_clear,
  input  logic             i_ap_start,
  input  logic             i_ap_ready,
  input  logic             i_ap_done,
  input  logic             i_ap_continue,
  output ap_mon_state_e    o_state,
  output logic [CNT_W-1:0] o_starts,
  output logic [CNT_W-1:0] o_dones,
  output logic [CNT_W-1:0] o_busy_cyc,
  output logic [CNT_W-1:0] o_stall_cyc,
  output logic [CNT_W-1:0] o_last_lat,
  output logic [CNT_W-1:0] o_max_lat,
  output logic [CNT_W-1:0] o_ready_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_overflow
);

  localparam logic [SAT_W-1:0] c_max = SAT_W'((65'd1 << CNT_W) - 65'd1);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(SAT_W'(v), c_max));
  endfunction

  ap_mon_state_e    r_state;
  ap_mon_state_e    w_state_nxt;
  logic [CNT_W-1:0] r_lat_cnt;
  logic [CNT_W-1:0] r_starts;
  logic [CNT_W-1:0] r_dones;
  logic [CNT_W-1:0] r_busy_cyc;
  logic [CNT_W-1:0] r_stall_cyc;
  logic [CNT_W-1:0] r_last_lat;
  logic [CNT_W-1:0] r_max_lat;
  logic [CNT_W-1:0] r_ready_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_overflow;

  logic             w_ev_start;
  logic             w_ev_done;
  logic             w_ev_lat;
  logic             w_ev_busy;
  logic             w_ev_stall;
  logic             w_ev_ready;
  logic             w_ev_err;
  logic             w_lat_rst;
  logic             w_ovf_hit;
  logic [CNT_W-1:0] w_lat_now;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= AP_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ev_start  = 1'b0;
    w_ev_done   = 1'b0;
    w_ev_lat    = 1'b0;
    w_ev_busy   = 1'b0;
    w_ev_stall  = 1'b0;
    w_ev_err    = 1'b0;
    w_lat_rst   = 1'b0;
    w_ev_ready  = i_ap_ready && (r_state != AP_HOLD);
    case (r_state)
      AP_IDLE: begin
        // A done with nothing in flight is only logged; a same-cycle start
        // is still honoured.
        w_ev_err = i_ap_done;
        if (i_ap_start) begin
          w_state_nxt = AP_RUN;
          w_ev_start  = 1'b1;
          w_lat_rst   = 1'b1;
        end
      end
      AP_RUN: begin
        w_ev_busy = 1'b1;
        if (i_ap_done) begin
          w_ev_lat = 1'b1;
          if (i_ap_continue) begin
            w_ev_done = 1'b1;
            if (i_ap_start) begin
              // Back-to-back invocation: stay in RUN, restart latency.
              w_ev_start = 1'b1;
              w_lat_rst  = 1'b1;
            end else begin
              w_state_nxt = AP_IDLE;
            end
          end else begin
            w_state_nxt = AP_HOLD;
          end
        end
      end
      AP_HOLD: begin
        // The done is only counted once the consumer accepts it.
        if (i_ap_continue) begin
          w_ev_done   = 1'b1;
          w_state_nxt = AP_IDLE;
        end else begin
          w_ev_stall = 1'b1;
        end
      end
      default: begin
        w_state_nxt = AP_IDLE;
      end
    endcase
  end

  // Latency counter tracks the FSM even while frozen or cleared so an
  // in-flight invocation still records a correct latency.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_lat_cnt <= '0;
    end else if (w_lat_rst) begin
      r_lat_cnt <= '0;
    end else if (r_state == AP_RUN) begin
      r_lat_cnt <= inc(r_lat_cnt);
    end
  end

  // Latency includes the done cycle itself.
  assign w_lat_now = inc(r_lat_cnt);

  assign w_ovf_hit = (w_ev_start && (&r_starts))    ||
                     (w_ev_done  && (&r_dones))     ||
                     (w_ev_busy  && (&r_busy_cyc))  ||
                     (w_ev_stall && (&r_stall_cyc)) ||
                     (w_ev_ready && (&r_ready_cnt)) ||
                     (w_ev_err   && (&r_err_cnt));

  always_ff @(posedge i_clock) begin
    if (!i_reset || i_clear) begin
      r_starts    <= '0;
      r_dones     <= '0;
      r_busy_cyc  <= '0;
      r_stall_cyc <= '0;
      r_last_lat  <= '0;
      r_max_lat   <= '0;
      r_ready_cnt <= '0;
      r_err_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else if (i_stat_en) begin
      if (w_ev_start) r_starts    <= inc(r_starts);
      if (w_ev_done)  r_dones     <= inc(r_dones);
      if (w_ev_busy)  r_busy_cyc  <= inc(r_busy_cyc);
      if (w_ev_stall) r_stall_cyc <= inc(r_stall_cyc);
      if (w_ev_ready) r_ready_cnt <= inc(r_ready_cnt);
      if (w_ev_err)   r_err_cnt   <= inc(r_err_cnt);
      if (w_ev_lat) begin
        r_last_lat <= w_lat_now;
        if (w_lat_now > r_max_lat) r_max_lat <= w_lat_now;
      end
      if (w_ovf_hit) r_overflow <= 1'b1;
    end
  end

  assign o_state     = r_state;
  assign o_starts    = r_starts;
  assign o_dones     = r_dones;
  assign o_busy_cyc  = r_busy_cyc;
  assign o_stall_cyc = r_stall_cyc;
  assign o_last_lat  = r_last_lat;
  assign o_max_lat   = r_max_lat;
  assign o_ready_cnt = r_ready_cnt;
  assign o_err_cnt   = r_err_cnt;
  assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ap_ctrl_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ap_ctrl_perf_monitor
// Description : Multi-channel ap_ctrl_chain handshake performance monitor.
//               Holds the freeze/clear control and the registered read mux;
//               per-channel tracking lives in ap_ch_tracker.
// Ports       : i_clock, i_reset (sync, active-low), i_finish (freeze),
//               i_clear (stat clear pulse), i_ap_start/ready/done/continue
//               [NUM_CH], i_rd_req/i_rd_ch/i_rd_sel read request,
//               o_rd_valid/o_rd_data read response (1 cycle later),
//               o_frozen, o_busy[NUM_CH].
// Revision    : 1.0 - initial release
// ============================================================================
module ap_ctrl_perf_monitor
  import ap_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_finish,
  input  logic              i_clear,
  input  logic [NUM_CH-1:0] i_ap_start,
  input  logic [NUM_CH-1:0] i_ap_ready,
  input  logic [NUM_CH-1:0] i_ap_done,
  input  logic [NUM_CH-1:0] i_ap_continue,
  input  logic              i_rd_req,
  input  logic [CH_W-1:0]   i_rd_ch,
  input  logic [2:0]        i_rd_sel,
  output logic              o_rd_valid,
  output logic [CNT_W-1:0]  o_rd_data,
  output logic              o_frozen,
  output logic [NUM_CH-1:0] o_busy
);

  logic             r_frozen;
  logic             r_rd_valid;
  logic [CNT_W-1:0] r_rd_data;
  logic [CNT_W-1:0] w_rd_mux;

  ap_mon_state_e    w_state     [NUM_CH];
  logic [CNT_W-1:0] w_starts    [NUM_CH];
  logic [CNT_W-1:0] w_dones     [NUM_CH];
  logic [CNT_W-1:0] w_busy_cyc  [NUM_CH];
  logic [CNT_W-1:0] w_stall_cyc [NUM_CH];
  logic [CNT_W-1:0] w_last_lat  [NUM_CH];
  logic [CNT_W-1:0] w_max_lat   [NUM_CH];
  logic [CNT_W-1:0] w_ready_cnt [NUM_CH];
  logic [CNT_W-1:0] w_err_cnt   [NUM_CH];
  logic [NUM_CH-1:0] w_overflow;

  // Statistics are gated by the registered flag, so the cycle in which
  // finish is first seen still updates.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_frozen <= 1'b0;
    end else if (i_clear) begin
      r_frozen <= 1'b0;
    end else if (i_finish) begin
      r_frozen <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ap_ch_tracker #(
      .CNT_W (CNT_W)
    ) u_trk (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_stat_en     (!r_frozen),
      .i_clear       (i_clear),
      .i_ap_start    (i_ap_start[g]),
      .i_ap_ready    (i_ap_ready[g]),
      .i_ap_done     (i_ap_done[g]),
      .i_ap_continue (i_ap_continue[g]),
      .o_state       (w_state[g]),
      .o_starts      (w_starts[g]),
      .o_dones       (w_dones[g]),
      .o_busy_cyc    (w_busy_cyc[g]),
      .o_stall_cyc   (w_stall_cyc[g]),
      .o_last_lat    (w_last_lat[g]),
      .o_max_lat     (w_max_lat[g]),
      .o_ready_cnt   (w_ready_cnt[g]),
      .o_err_cnt     (w_err_cnt[g]),
      .o_overflow    (w_overflow[g])
    );

    assign o_busy[g] = (w_state[g] != AP_IDLE);
  end

  // Channels beyond NUM_CH never match and read back as zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_rd_ch == CH_W'(i)) begin
        case (i_rd_sel)
          SEL_STARTS:   w_rd_mux = w_starts[i];
          SEL_DONES:    w_rd_mux = w_dones[i];
          SEL_BUSY:     w_rd_mux = w_busy_cyc[i];
          SEL_STALL:    w_rd_mux = w_stall_cyc[i];
          SEL_LAST_LAT: w_rd_mux = w_last_lat[i];
          SEL_MAX_LAT:  w_rd_mux = w_max_lat[i];
          SEL_READY:    w_rd_mux = w_ready_cnt[i];
          SEL_STATUS:   w_rd_mux = {w_err_cnt[i][CNT_W-4:0], w_overflow[i], w_state[i]};
        endcase
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= i_rd_req;
      r_rd_data  <= i_rd_req ? w_rd_mux : '0;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_frozen   = r_frozen;

endmodule
`default_nettype wire

// File: tb/tb_ap_ctrl_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ap_ctrl_perf_monitor
// Description : Directed self-checking bench for ap_ctrl_perf_monitor. A
//               default 4-channel/32-bit instance covers the handshake,
//               freeze, clear and reset behaviour; a 3-channel/4-bit
//               instance covers saturation and out-of-range channel reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ap_ctrl_perf_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        finish;
  logic        clear;
  logic [3:0]  start, ready, done, cont;
  logic        rd_req;
  logic [1:0]  rd_ch;
  logic [2:0]  rd_sel;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        frozen;
  logic [3:0]  busy;

  logic        b_finish;
  logic        b_clear;
  logic [2:0]  b_start, b_ready, b_done, b_cont;
  logic        b_rd_req;
  logic [1:0]  b_rd_ch;
  logic [2:0]  b_rd_sel;
  logic        b_rd_valid;
  logic [3:0]  b_rd_data;
  logic        b_frozen;
  logic [2:0]  b_busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32)) u_dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_finish      (finish),
    .i_clear       (clear),
    .i_ap_start    (start),
    .i_ap_ready    (ready),
    .i_ap_done     (done),
    .i_ap_continue (cont),
    .i_rd_req      (rd_req),
    .i_rd_ch       (rd_ch),
    .i_rd_sel      (rd_sel),
    .o_rd_valid    (rd_valid),
    .o_rd_data     (rd_data),
    .o_frozen      (frozen),
    .o_busy        (busy)
  );

  ap_ctrl_perf_monitor #(.NUM_CH(3), .CNT_W(4)) u_dut_sat (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_finish      (b_finish),
    .i_clear       (b_clear),
    .i_ap_start    (b_start),
    .i_ap_ready    (b_ready),
    .i_ap_done     (b_done),
    .i_ap_continue (b_cont),
    .i_rd_req      (b_rd_req),
    .i_rd_ch       (b_rd_ch),
    .i_rd_sel      (b_rd_sel),
    .o_rd_valid    (b_rd_valid),
    .o_rd_data     (b_rd_data),
    .o_frozen      (b_frozen),
    .o_busy        (b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int ch, input int sel, input int exp, input string tag);
    rd_req = 1'b1;
    rd_ch  = 2'(ch);
    rd_sel = 3'(sel);
    tick;
    rd_req = 1'b0;
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic rdb(input int ch, input int sel, input int exp, input string tag);
    b_rd_req = 1'b1;
    b_rd_ch  = 2'(ch);
    b_rd_sel = 3'(sel);
    tick;
    b_rd_req = 1'b0;
    chk({tag, "_valid"}, 64'(b_rd_valid), 64'd1);
    chk(tag, 64'(b_rd_data), 64'(exp));
  endtask

  initial begin
    rst_n = 1'b0; finish = 1'b0; clear = 1'b0;
    start = '0; ready = '0; done = '0; cont = '1;
    rd_req = 1'b0; rd_ch = '0; rd_sel = '0;
    b_finish = 1'b0; b_clear = 1'b0;
    b_start = '0; b_ready = '0; b_done = '0; b_cont = '1;
    b_rd_req = 1'b0; b_rd_ch = '0; b_rd_sel = '0;

    // Reset state
    repeat (3) tick;
    chk("rst_valid",  64'(rd_valid), 64'd0);
    chk("rst_data",   64'(rd_data),  64'd0);
    chk("rst_frozen", 64'(frozen),   64'd0);
    chk("rst_busy",   64'(busy),     64'd0);
    rst_n = 1'b1;
    tick;

    // ch0: single invocation, latency 3
    start[0] = 1'b1; tick; start[0] = 1'b0;
    chk("ch0_busy_run", 64'(busy[0]), 64'd1);
    tick; tick;
    done[0] = 1'b1; tick; done[0] = 1'b0;
    chk("ch0_busy_idle", 64'(busy[0]), 64'd0);
    rd(0, 0, 1, "ch0_starts");
    rd(0, 1, 1, "ch0_dones");
    rd(0, 2, 3, "ch0_busy_cyc");
    rd(0, 4, 3, "ch0_last_lat");
    rd(0, 5, 3, "ch0_max_lat");

    // ch1: done with continue low, three stall cycles, then release
    cont[1] = 1'b0;
    start[1] = 1'b1; tick; start[1] = 1'b0;
    rd(1, 7, 1, "ch1_state_run");
    tick;
    done[1] = 1'b1; ready[1] = 1'b1; tick; done[1] = 1'b0;
    rd(1, 7, 2, "ch1_state_hold");
    ready[1] = 1'b0;
    rd(1, 1, 0, "ch1_dones_hold");
    tick;
    cont[1] = 1'b1; tick;
    rd(1, 3, 3, "ch1_stall");
    rd(1, 1, 1, "ch1_dones");
    rd(1, 7, 0, "ch1_state_idle");
    rd(1, 6, 1, "ch1_ready");
    rd(1, 4, 3, "ch1_last_lat");

    // ch2: four back-to-back invocations of latency 2
    start[2] = 1'b1; tick; start[2] = 1'b0;
    tick;
    for (int k = 0; k < 3; k++) begin
      done[2] = 1'b1; start[2] = 1'b1; tick;
      done[2] = 1'b0; start[2] = 1'b0;
      chk("ch2_busy_b2b", 64'(busy[2]), 64'd1);
      tick;
    end
    done[2] = 1'b1; tick; done[2] = 1'b0;
    chk("ch2_busy_end", 64'(busy[2]), 64'd0);
    rd(2, 0, 4, "ch2_starts");
    rd(2, 1, 4, "ch2_dones");
    rd(2, 2, 8, "ch2_busy_cyc");
    rd(2, 5, 2, "ch2_max_lat");

    // ch3: spurious done while idle
    done[3] = 1'b1; tick; done[3] = 1'b0;
    chk("ch3_err_busy", 64'(busy[3]), 64'd0);
    rd(3, 7, 8, "ch3_err_status");

    // Freeze with ch3 running; finish-cycle event still counted
    start[3] = 1'b1; tick; start[3] = 1'b0;
    tick; tick;
    finish = 1'b1; tick; finish = 1'b0;
    chk("frz_frozen", 64'(frozen), 64'd1);
    repeat (5) tick;
    rd(3, 2, 3, "frz_ch3_busy_cyc");
    rd(3, 0, 1, "frz_ch3_starts");
    done[3] = 1'b1; tick; done[3] = 1'b0;
    chk("frz_ch3_busy_tracks", 64'(busy[3]), 64'd0);
    rd(3, 1, 0, "frz_ch3_dones");
    rd(0, 0, 1, "frz_ch0_starts");
    chk("frz_still_frozen", 64'(frozen), 64'd1);

    // Clear
    clear = 1'b1; tick; clear = 1'b0;
    chk("clr_frozen", 64'(frozen), 64'd0);
    rd(0, 0, 0, "clr_ch0_starts");
    rd(3, 7, 0, "clr_ch3_status");

    // Reset while ch1 is in HOLD
    cont[1] = 1'b0;
    start[1] = 1'b1; tick; start[1] = 1'b0;
    done[1] = 1'b1; tick; done[1] = 1'b0;
    tick; tick;
    chk("hold_busy", 64'(busy[1]), 64'd1);
    rst_n = 1'b0; rd_req = 1'b1; rd_ch = 2'd1; rd_sel = 3'd3;
    tick;
    chk("rst2_valid", 64'(rd_valid), 64'd0);
    chk("rst2_busy",  64'(busy),     64'd0);
    rd_req = 1'b0; rst_n = 1'b1; cont[1] = 1'b1;
    tick;
    rd(1, 7, 0, "rst2_ch1_status");
    rd(1, 3, 0, "rst2_ch1_stall");
    rd(1, 0, 0, "rst2_ch1_starts");

    // 4-bit counters: saturation, overflow and clear priority
    b_start[0] = 1'b1; tick; b_start[0] = 1'b0;
    repeat (20) tick;
    rdb(0, 2, 15, "sat_busy_cyc");
    rdb(0, 7, 5, "sat_status");
    b_clear = 1'b1; tick; b_clear = 1'b0;
    rdb(0, 2, 0, "sat_clr_busy_cyc");
    rdb(0, 7, 1, "sat_clr_status");
    b_done[0] = 1'b1; tick; b_done[0] = 1'b0;
    rdb(0, 4, 15, "sat_last_lat");
    rdb(0, 5, 15, "sat_max_lat");
    rdb(3, 5, 0, "oob_channel");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
